// File: rtl/mov_imm_sequencer.sv
// mov_imm_sequencer: turns a 64-bit constant into the LEGv8 MOVZ/MOVK sequence
// that rebuilds it in register Rd. One instruction is emitted per accepted
// output beat (OutValid/OutReady).
//
// Ports:
//   CLK, Reset            clock (rising edge), async active-high reset
//   InValid/InReady       input handshake for Const/Rd
//   Const[63:0], Rd[4:0]  constant to materialise and destination register
//   OutValid/OutReady     output handshake
//   Instr[31:0]           {opcode[8:0], hw[1:0], imm16[15:0], Rd[4:0]}
//   Imm26[25:0]           Instr[25:0]
//   Ctrl[2:0]             {1'b1, hw}, the sign-extender selector for this beat
//   OutLast               final instruction of the sequence
//   Count[2:0]            total instructions in the current sequence
//
// Optional feature: define MOVN_EN to start mostly-ones constants with MOVN.
`timescale 1ns/1ps
module mov_imm_sequencer #(
    parameter logic [8:0] OPC_MOVZ  = 9'b110100101,
    parameter logic [8:0] OPC_MOVK  = 9'b111100101,
    parameter bit         SKIP_ZERO = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [63:0] Const,
    input  logic [4:0]  Rd,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] Instr,
    output logic [25:0] Imm26,
    output logic [2:0]  Ctrl,
    output logic        OutLast,
    output logic [2:0]  Count
);

`ifdef MOVN_EN
    localparam logic [8:0] OPC_MOVN = 9'b100100101;
`endif

    typedef enum logic {IDLE, EMIT} state_e;

    state_e      state_q, state_d;
    logic [63:0] const_q, const_d;
    logic [4:0]  rd_q, rd_d;
    logic [3:0]  pend_q, pend_d;       // halfwords still to be emitted
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        last_q, last_d;
    logic [2:0]  count_q, count_d;

    // Scratch for building the next instruction
    logic        ld;
    logic [3:0]  mask_c;
    logic [1:0]  hw_c;
    logic [15:0] imm_c;
    logic [8:0]  opc_c;
    logic [4:0]  rd_c;
`ifdef MOVN_EN
    logic [2:0]  nf_c, nz_c;
`endif

    function automatic logic [1:0] lowest_hw(input logic [3:0] m);
        lowest_hw = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_hw = 2'(i);
        end
    endfunction

    function automatic logic [2:0] popcnt4(input logic [3:0] m);
        popcnt4 = 3'd0;
        for (int i = 0; i < 4; i++) begin
            popcnt4 = popcnt4 + 3'(m[i]);
        end
    endfunction

    function automatic logic [15:0] halfword(input logic [63:0] c, input logic [1:0] hw);
        case (hw)
            2'd0:    halfword = c[15:0];
            2'd1:    halfword = c[31:16];
            2'd2:    halfword = c[47:32];
            default: halfword = c[63:48];
        endcase
    endfunction

    // State and output registers
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            const_q     <= 64'd0;
            rd_q        <= 5'd0;
            pend_q      <= 4'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            instr_q     <= 32'd0;
            ctrl_q      <= 3'd0;
            last_q      <= 1'b0;
            count_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            const_q     <= const_d;
            rd_q        <= rd_d;
            pend_q      <= pend_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            ctrl_q      <= ctrl_d;
            last_q      <= last_d;
            count_q     <= count_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        const_d     = const_q;
        rd_d        = rd_q;
        pend_d      = pend_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        ctrl_d      = ctrl_q;
        last_d      = last_q;
        count_d     = count_q;
        ld          = 1'b0;
        mask_c      = 4'd0;
        hw_c        = 2'd0;
        imm_c       = 16'd0;
        opc_c       = OPC_MOVK;
        rd_c        = rd_q;
`ifdef MOVN_EN
        nf_c        = 3'd0;
        nz_c        = 3'd0;
`endif

        case (state_q)
            IDLE: begin
                // in_ready_q stays low for the first cycle after reset release
                in_ready_d = 1'b1;
                if (InValid && in_ready_q) begin
                    for (int i = 0; i < 4; i++) begin
                        mask_c[i] = !SKIP_ZERO || (Const[16*i +: 16] != 16'd0);
                    end
                    hw_c  = lowest_hw(mask_c);
                    imm_c = halfword(Const, hw_c);
                    opc_c = OPC_MOVZ;
`ifdef MOVN_EN
                    for (int i = 0; i < 4; i++) begin
                        nf_c = nf_c + 3'(Const[16*i +: 16] == 16'hFFFF);
                        nz_c = nz_c + 3'(Const[16*i +: 16] == 16'h0000);
                    end
                    if (nf_c > nz_c) begin
                        for (int i = 0; i < 4; i++) begin
                            mask_c[i] = (Const[16*i +: 16] != 16'hFFFF);
                        end
                        hw_c  = lowest_hw(mask_c);
                        imm_c = ~halfword(Const, hw_c);
                        opc_c = OPC_MOVN;
                    end
`endif
                    rd_c       = Rd;
                    ld         = 1'b1;
                    const_d    = Const;
                    rd_d       = Rd;
                    // Empty mask still emits one instruction at hw0
                    pend_d     = mask_c & ~(4'b0001 << hw_c);
                    count_d    = (mask_c == 4'd0) ? 3'd1 : popcnt4(mask_c);
                    in_ready_d = 1'b0;
                    state_d    = EMIT;
                end
            end
            EMIT: begin
                if (OutReady) begin
                    if (last_q) begin
                        state_d     = IDLE;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        instr_d     = 32'd0;
                        ctrl_d      = 3'd0;
                        last_d      = 1'b0;
                        count_d     = 3'd0;
                    end else begin
                        hw_c   = lowest_hw(pend_q);
                        imm_c  = halfword(const_q, hw_c);
                        opc_c  = OPC_MOVK;
                        ld     = 1'b1;
                        pend_d = pend_q & ~(4'b0001 << hw_c);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (ld) begin
            out_valid_d = 1'b1;
            instr_d     = {opc_c, hw_c, imm_c, rd_c};
            ctrl_d      = {1'b1, hw_c};
            last_d      = (pend_d == 4'd0);
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = out_valid_q;
    assign Instr    = instr_q;
    assign Imm26    = instr_q[25:0];
    assign Ctrl     = ctrl_q;
    assign OutLast  = last_q;
    assign Count    = count_q;

endmodule
